stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
Multicycle stage sequencer that sits directly upstream of the control unit. It produces the 3-bit `next_state` stage code (IF/ID/EX/MEM/WB) that the control unit samples on negedge to gate RegWrite1/2, MemWrite and the PC update. The stage path is chosen per opcode class. MEM is held while memory is not ready, with a bounded timeout. It also reports instruction completion and illegal opcodes.

Parameters:
- `MEM_TIMEOUT`, 15: maximum consecutive MEM stall cycles before abort; range 1..255.
- `CNT_W`, 32: width of the performance counters (used only with the optional feature).

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `op_code`  in  6  opcode from the instruction register; valid during ID.
- `mem_ready`  in  1  memory completion; sampled only while in MEM.
- `next_state`  out  3  current stage code: IF=000, ID=001, EX=010, MEM=011, WB=100.
- `op_latched`  out  6  opcode captured at the ID->next edge; held until the next ID.
- `instr_done`  out  1  one-cycle pulse on normal return to IF.
- `illegal_op`  out  1  one-cycle pulse when an undefined opcode returns to IF.
- `mem_timeout`  out  1  one-cycle pulse when a MEM stall aborts.

Behaviour:
- Reset: on a posedge with `rst`=1:
  - `next_state`=IF, `op_latched`=0.
  - `instr_done`, `illegal_op` and `mem_timeout` = 0.
  - Stall counter = 0; perf counters = 0.
  - Reset overrides all other activity in any stage, including mid-MEM stall.
- IF: always one cycle, then ID.
- ID: one cycle. At the leaving edge, capture `op_code` into `op_latched`. The next stage is decoded from live `op_code`; all later transitions use `op_latched`.
- Paths (stage sequence, then return to IF):
  - ALU: opcodes 000000-000100 (AND/ADD/SUB/ANDI/ADDI): EX, WB.
  - Load: 000101 (LW), 000110 (LW.POI): EX, MEM, WB.
  - Store: 000111 (SW): EX, MEM.
  - Branch: 0010xx: EX.
  - Jump: 001100 (JMP): straight from ID.
  - Stack write: 001101 (CALL), 001111 (PUSH): MEM.
  - Stack read: 001110 (RET): MEM. 010000 (POP): MEM, WB.
  - Undefined (any other opcode): ID->IF; `illegal_op` pulses instead of `instr_done`.
- MEM stall:
  - While in MEM with `mem_ready`=0, hold MEM and increment the stall counter.
  - With `mem_ready`=1, advance per path and clear the counter.
  - If the counter equals `MEM_TIMEOUT` while still not ready: go to IF, pulse `mem_timeout`, no `instr_done`, clear the counter.
- Pulse timing: `instr_done`, `illegal_op` and `mem_timeout` are registered. Each is high exactly in the first cycle `next_state`=IF after the terminating edge, and never two at once.
- Unreachable stage codes (101-111) recover to IF on the next edge with no pulses.
- Throughput is strictly one instruction in flight; no overlap.
- Stall counter width is `$clog2(MEM_TIMEOUT+1)` bits; it never wraps.

Optional Feature:
Macro `STAGE_SEQ_PERF_EN`.
- Defined: adds outputs `cycle_cnt` [`CNT_W`] and `instr_cnt` [`CNT_W`].
  - `cycle_cnt` increments every non-reset cycle.
  - `instr_cnt` increments on each `instr_done`.
  - Both wrap modulo 2^`CNT_W` and clear on `rst`.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - Stage encodings IF_STAGE..WB_STAGE (same values as the control unit).
  - Opcode constants.
  - Instruction-class enum: CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_STK_WR, CLS_STK_RD, CLS_POP, CLS_ILLEGAL.
- Sub-module `op_classifier`: combinational opcode -> class decoder. It is reused by the control unit and the testbench scoreboard.

Test Plan:
1. Reset, then ADD (000001) with `mem_ready`=1 -> `next_state` goes 0,1,2,4,0; `instr_done` high only in the final IF cycle; cycle 5 is IF.
2. LW (000101), `mem_ready` low for 3 MEM cycles then high -> 0,1,2,3,3,3,3,4,0; `op_latched`=000101 from cycle 3 onward.
3. BEQ (001010), then JMP (001100) -> 0,1,2,0 followed by 0,1,0; two `instr_done` pulses.
4. Opcode 111111 -> 0,1,0; `illegal_op`=1 for one cycle; `instr_done` stays 0.
5. `MEM_TIMEOUT`=4, PUSH (001111), `mem_ready` held 0 -> MEM for exactly 5 cycles, then IF with `mem_timeout`=1 for one cycle; no `instr_done`.
6. `rst` asserted during the 2nd MEM stall cycle of SW -> next edge: `next_state`=0, all pulses 0. With `STAGE_SEQ_PERF_EN`, both counters read 0, then `instr_cnt`=1 after one ADD completes.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer and its consumers: stage codes
// (identical to the control unit's), opcode constants and instruction classes.
package stage_sequencer_pkg;

  // Stage codes sampled by the control unit on negedge.
  typedef enum logic [2:0] {
    IF_STAGE  = 3'b000,
    ID_STAGE  = 3'b001,
    EX_STAGE  = 3'b010,
    MEM_STAGE = 3'b011,
    WB_STAGE  = 3'b100
  } stage_e;

  // Opcodes with a defined stage path.
  localparam logic [5:0] OP_AND    = 6'b000000;
  localparam logic [5:0] OP_ADD    = 6'b000001;
  localparam logic [5:0] OP_SUB    = 6'b000010;
  localparam logic [5:0] OP_ANDI   = 6'b000011;
  localparam logic [5:0] OP_ADDI   = 6'b000100;
  localparam logic [5:0] OP_LW     = 6'b000101;
  localparam logic [5:0] OP_LW_POI = 6'b000110;
  localparam logic [5:0] OP_SW     = 6'b000111;
  localparam logic [5:0] OP_JMP    = 6'b001100;
  localparam logic [5:0] OP_CALL   = 6'b001101;
  localparam logic [5:0] OP_RET    = 6'b001110;
  localparam logic [5:0] OP_PUSH   = 6'b001111;
  localparam logic [5:0] OP_POP    = 6'b010000;

  // Instruction classes; each selects one stage path.
  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_STK_WR,
    CLS_STK_RD,
    CLS_POP,
    CLS_ILLEGAL
  } op_class_e;

  // How an instruction leaves the sequencer; selects which pulse fires.
  typedef enum logic [1:0] {
    END_NONE,
    END_DONE,
    END_ILLEGAL,
    END_TIMEOUT
  } end_e;

endpackage

// File: rtl/stage_sequencer_op_classifier.sv
// Combinational opcode -> instruction-class decoder.
module op_classifier
  import stage_sequencer_pkg::*;
(
  input  logic [5:0] op_code,
  output op_class_e  op_class
);

  // Map each opcode to its class; anything unlisted is illegal.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    op_class = CLS_ILLEGAL;
    casez (op_code)
      OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI: op_class = CLS_ALU;
      OP_LW, OP_LW_POI:                         op_class = CLS_LOAD;
      OP_SW:                                    op_class = CLS_STORE;
      6'b0010??:                                op_class = CLS_BRANCH;
      OP_JMP:                                   op_class = CLS_JUMP;
      OP_CALL, OP_PUSH:                         op_class = CLS_STK_WR;
      OP_RET:                                   op_class = CLS_STK_RD;
      OP_POP:                                   op_class = CLS_POP;
      default:                                  op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer feeding the control unit.
// Walks IF/ID/EX/MEM/WB along a per-class path, holds MEM while memory is
// busy (bounded by MEM_TIMEOUT) and pulses completion / illegal / timeout.
// Optional: define STAGE_SEQ_PERF_EN to add cycle and instruction counters.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic             mem_ready,
  output logic [2:0]       next_state,
  output logic [5:0]       op_latched,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout
`ifdef STAGE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam int STALL_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MEM_TIMEOUT);

  stage_e             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  end_e               end_d;
  op_class_e          live_cls, lat_cls;

  // ID decodes the live opcode; every later stage uses the captured one.
  op_classifier u_live_cls (.op_code(op_code),    .op_class(live_cls));
  op_classifier u_lat_cls  (.op_code(op_latched), .op_class(lat_cls));

  assign next_state = state_q;

  // Next stage, stall count and termination kind from the current stage.
  always_comb begin
    state_d = IF_STAGE;
    stall_d = '0;
    end_d   = END_NONE;
    case (state_q)
      IF_STAGE: state_d = ID_STAGE;
      ID_STAGE: begin
        case (live_cls)
          CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: state_d = EX_STAGE;
          CLS_STK_WR, CLS_STK_RD, CLS_POP:          state_d = MEM_STAGE;
          CLS_JUMP:                                 end_d   = END_DONE;
          default:                                  end_d   = END_ILLEGAL;
        endcase
      end
      EX_STAGE: begin
        case (lat_cls)
          CLS_ALU:             state_d = WB_STAGE;
          CLS_LOAD, CLS_STORE: state_d = MEM_STAGE;
          CLS_BRANCH:          end_d   = END_DONE;
          default:             end_d   = END_NONE;
        endcase
      end
      MEM_STAGE: begin
        if (mem_ready) begin
          if (lat_cls == CLS_LOAD || lat_cls == CLS_POP) state_d = WB_STAGE;
          else                                           end_d   = END_DONE;
        end else if (stall_q == STALL_LIMIT) begin
          // Counter stops at the limit, so it can never wrap.
          end_d = END_TIMEOUT;
        end else begin
          state_d = MEM_STAGE;
          stall_d = stall_q + STALL_W'(1);
        end
      end
      WB_STAGE: end_d = END_DONE;
      // Codes 101-111 fall back to IF silently.
      default:  state_d = IF_STAGE;
    endcase
  end

  // State, captured opcode and registered termination pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q     <= IF_STAGE;
      stall_q     <= '0;
      op_latched  <= '0;
      instr_done  <= 1'b0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      if (state_q == ID_STAGE) op_latched <= op_code;
      instr_done  <= (end_d == END_DONE);
      illegal_op  <= (end_d == END_ILLEGAL);
      mem_timeout <= (end_d == END_TIMEOUT);
    end
  end

`ifdef STAGE_SEQ_PERF_EN
  // Free-running cycle count and completed-instruction count, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (end_d == END_DONE) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer. A reference model expands each
// instruction into its per-cycle stage trace; a driver plays the stimulus
// and a monitor compares DUT outputs every cycle against the expected queue.
module tb_stage_sequencer;

  localparam int T = 4;  // MEM_TIMEOUT used for the DUT

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op_code;
  logic        mem_ready;
  logic [2:0]  next_state;
  logic [5:0]  op_latched;
  logic        instr_done, illegal_op, mem_timeout;
`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  stage_sequencer #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_code    (op_code),
    .mem_ready  (mem_ready),
    .next_state (next_state),
    .op_latched (op_latched),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout)
`ifdef STAGE_SEQ_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit [5:0] op;
    bit       rdy;
  } stim_t;

  typedef struct {
    bit [2:0]    st;
    bit [5:0]    lat;
    bit          done;
    bit          ill;
    bit          tmo;
    int unsigned cyc;
    int unsigned icnt;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int errors = 0;
  int checks = 0;
  bit run    = 1'b0;
  int cyc_idx = 0;

  // Model state: captured opcode, pending termination (0 none, 1 done,
  // 2 illegal, 3 timeout), cycles since reset and completed instructions.
  bit [5:0]    m_lat;
  int          m_pend;
  int unsigned m_cyc, m_icnt;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Stage list an opcode walks after ID: E=EX, M=MEM, W=WB, X=undefined.
  function automatic string path_of(input bit [5:0] op);
    if (op <= 6'd4)                 return "EW";
    if (op == 6'd5 || op == 6'd6)   return "EMW";
    if (op == 6'd7)                 return "EM";
    if (op >= 6'd8 && op <= 6'd11)  return "E";
    if (op == 6'd12)                return "";
    if (op >= 6'd13 && op <= 6'd15) return "M";
    if (op == 6'd16)                return "MW";
    return "X";
  endfunction

  // Record one cycle: expected outputs during it and inputs applied in it.
  task automatic push(input bit [2:0] st, input bit [5:0] op, input bit rdy, input bit r);
    exp_t  e;
    stim_t s;
    if (st == 3'd0 && m_pend == 1) m_icnt++;
    e.st   = st;
    e.lat  = m_lat;
    e.done = (st == 3'd0 && m_pend == 1);
    e.ill  = (st == 3'd0 && m_pend == 2);
    e.tmo  = (st == 3'd0 && m_pend == 3);
    e.cyc  = m_cyc;
    e.icnt = m_icnt;
    if (st == 3'd0) m_pend = 0;
    exp_q.push_back(e);
    s.rst = r;
    s.op  = op;
    s.rdy = rdy;
    stim_q.push_back(s);
    m_cyc++;
    if (r) begin
      m_lat  = '0;
      m_pend = 0;
      m_cyc  = 0;
      m_icnt = 0;
    end
  endtask

  // Expand one instruction. stall = not-ready MEM cycles before ready;
  // rst_mem = which MEM cycle (1-based) asserts reset, 0 for none.
  // Opcode and mem_ready carry junk wherever the DUT must ignore them.
  task automatic gen_instr(input bit [5:0] op, input int stall, input int rst_mem);
    string p;
    p = path_of(op);
    push(3'd0, 6'($urandom), 1'($urandom), 1'b0);
    push(3'd1, op, 1'($urandom), 1'b0);
    m_lat = op;
    if (p == "X") begin
      m_pend = 2;
      return;
    end
    for (int i = 0; i < p.len(); i++) begin
      if (p[i] == "E") push(3'd2, 6'($urandom), 1'($urandom), 1'b0);
      else if (p[i] == "W") push(3'd4, 6'($urandom), 1'($urandom), 1'b0);
      else begin
        for (int k = 0; k <= T; k++) begin
          if (rst_mem == k + 1) begin
            push(3'd3, 6'($urandom), 1'b0, 1'b1);
            return;
          end
          if (k < stall) begin
            push(3'd3, 6'($urandom), 1'b0, 1'b0);
            if (k == T) begin
              m_pend = 3;
              return;
            end
          end else begin
            push(3'd3, 6'($urandom), 1'b1, 1'b0);
            break;
          end
        end
      end
    end
    m_pend = 1;
  endtask

  // Monitor: compare every cycle's outputs with the next expected entry.
  always @(negedge clk) begin
    if (run && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("next_state",  cyc_idx, 32'(next_state),  32'(e.st));
      check("op_latched",  cyc_idx, 32'(op_latched),  32'(e.lat));
      check("instr_done",  cyc_idx, 32'(instr_done),  32'(e.done));
      check("illegal_op",  cyc_idx, 32'(illegal_op),  32'(e.ill));
      check("mem_timeout", cyc_idx, 32'(mem_timeout), 32'(e.tmo));
`ifdef STAGE_SEQ_PERF_EN
      check("cycle_cnt",   cyc_idx, cycle_cnt,        e.cyc);
      check("instr_cnt",   cyc_idx, instr_cnt,        e.icnt);
`endif
      cyc_idx++;
    end
  end

  // Generate the full stream, reset the DUT, then play the stimulus.
  initial begin
    bit [5:0] legal [17];
    stim_t    s;
    for (int i = 0; i < 17; i++) legal[i] = 6'(i);
    m_lat  = '0;
    m_pend = 0;
    m_cyc  = 0;
    m_icnt = 0;

    gen_instr(6'b000001, 0, 0);    // ADD
    gen_instr(6'b000101, 3, 0);    // LW, three stall cycles
    gen_instr(6'b001010, 0, 0);    // BEQ
    gen_instr(6'b001100, 0, 0);    // JMP
    gen_instr(6'b111111, 0, 0);    // undefined
    gen_instr(6'b001111, 100, 0);  // PUSH, never ready -> timeout
    gen_instr(6'b000111, 100, 2);  // SW, reset in 2nd stall cycle
    gen_instr(6'b000001, 0, 0);    // ADD after reset
    gen_instr(6'b010000, T, 0);    // POP, ready exactly at the limit
    for (int n = 0; n < 150; n++) begin
      bit [5:0] op;
      int       rm;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 16)];
      rm = ($urandom_range(0, 19) == 0) ? $urandom_range(1, T + 1) : 0;
      gen_instr(op, $urandom_range(0, T + 2), rm);
    end
    push(3'd0, 6'd0, 1'b0, 1'b0);

    rst       = 1'b1;
    op_code   = '0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    run = 1'b1;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      s         = stim_q.pop_front();
      rst       = s.rst;
      op_code   = s.op;
      mem_ready = s.rdy;
    end
    #1;
    check("drain", cyc_idx, 32'(exp_q.size()), 32'd0);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
